// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker commit checker.
package tinker_pkg;

   localparam int DATA_W    = 64;
   localparam int INSTR_W   = 32;
   localparam int REG_AW    = 5;
   // idx field is sized for the default 16-entry table
   localparam int ENT_IDX_W = 4;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_001f;

   // opcode field lives in instr[4:0]
   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_SUB   = 5'h02;
   localparam logic [4:0] OP_SHFTR = 5'h0a;
   localparam logic [4:0] OP_MOV   = 5'h17;
   localparam logic [4:0] OP_NOP   = 5'h1f;

   function automatic logic [4:0] opcode(input logic [INSTR_W-1:0] i);
      return i[4:0];
   endfunction

   typedef struct packed {
      logic                 chk;
      logic [REG_AW-1:0]    exp_reg;
      logic [DATA_W-1:0]    exp_dat;
      logic [ENT_IDX_W-1:0] idx;
   } chk_ent_t;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

endpackage

// File: rtl/tinker_lat_pipe.sv
// Fixed-latency valid+payload shift pipe; slot STAGES-1 is what emerges this cycle.
module tinker_lat_pipe #(
   parameter int STAGES = 4,
   parameter int W      = 8
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld_i,
   input  logic [W-1:0] in_dat_i,
   output logic         out_vld_o,
   output logic [W-1:0] out_dat_o
);

   logic [STAGES-1:0]        vld_q;
   logic [STAGES-1:0][W-1:0] dat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q[0] <= in_vld_i;
         dat_q[0] <= in_dat_i;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_vld_o = vld_q[STAGES-1];
   assign out_dat_o = dat_q[STAGES-1];

endmodule

// File: rtl/tinker_commit_checker.sv
// Replays a programmed instruction table into the decoder and checks each
// register writeback a fixed COMMIT_LAT cycles after issue.
module tinker_commit_checker
   import tinker_pkg::*;
#(
   parameter int  NUM_ENT    = 16,
   parameter int  COMMIT_LAT = 4,
   localparam int IDX_W      = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1,
   localparam int CNT_W      = $clog2(NUM_ENT + 1)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [INSTR_W-1:0] cfg_instr,
   input  logic               cfg_chk,
   input  logic [REG_AW-1:0]  cfg_exp_reg,
   input  logic [DATA_W-1:0]  cfg_exp_dat,
   input  logic               start,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               wb_en,
   input  logic [REG_AW-1:0]  wb_reg,
   input  logic [DATA_W-1:0]  wb_dat,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   fail_cnt,
   output logic [IDX_W-1:0]   first_fail
);

   localparam int TBL_D = 2 ** IDX_W;
   localparam int DRN_W = (COMMIT_LAT > 1) ? $clog2(COMMIT_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENT - 1);
   localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(COMMIT_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_ENT);

   logic [INSTR_W-1:0] tbl_instr_q [TBL_D];
   logic               tbl_chk_q   [TBL_D];
   logic [REG_AW-1:0]  tbl_reg_q   [TBL_D];
   logic [DATA_W-1:0]  tbl_dat_q   [TBL_D];

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   iss_q, iss_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic [IDX_W-1:0]   first_fail_q, first_fail_d;
   logic               pass_q, pass_d;

   chk_ent_t           push_ent, pop_ent;
   logic               push_vld, pop_vld, chk_fail;

   // Table has no reset so a programmed test survives a core reset.
   always_ff @(posedge clk) begin
      if (cfg_we && state_q == IDLE) begin
         tbl_instr_q[cfg_idx] <= cfg_instr;
         tbl_chk_q[cfg_idx]   <= cfg_chk;
         tbl_reg_q[cfg_idx]   <= cfg_exp_reg;
         tbl_dat_q[cfg_idx]   <= cfg_exp_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ISSUE;
         ISSUE:   if (iss_q == LAST_IDX) state_d = DRAIN;
         DRAIN:   if (drn_q == LAST_DRN) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      instr       = NOP_INSTR;
      instr_valid = 1'b0;
      busy        = (state_q != IDLE);
      done        = (state_q == DONE);
      if (state_q == ISSUE) begin
         instr_valid = 1'b1;
         if (tbl_chk_q[iss_q]) instr = tbl_instr_q[iss_q];
      end
   end

   always_comb begin
      push_vld         = (state_q == ISSUE);
      push_ent         = '0;
      push_ent.chk     = tbl_chk_q[iss_q];
      push_ent.exp_reg = tbl_reg_q[iss_q];
      push_ent.exp_dat = tbl_dat_q[iss_q];
      push_ent.idx     = ENT_IDX_W'(iss_q);
   end

   tinker_lat_pipe #(
      .STAGES (COMMIT_LAT),
      .W      ($bits(chk_ent_t))
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld_i  (push_vld),
      .in_dat_i  (push_ent),
      .out_vld_o (pop_vld),
      .out_dat_o (pop_ent)
   );

   always_comb begin
      chk_fail = 1'b0;
      if (pop_vld) begin
         if (pop_ent.chk)
            chk_fail = !(wb_en && wb_reg == pop_ent.exp_reg && wb_dat == pop_ent.exp_dat);
         else
            chk_fail = wb_en;
      end
   end

   always_comb begin
      iss_d        = iss_q;
      drn_d        = drn_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      if (state_q == ISSUE) iss_d = (iss_q == LAST_IDX) ? '0 : iss_q + 1'b1;
      if (state_q == DRAIN) drn_d = (drn_q == LAST_DRN) ? '0 : drn_q + 1'b1;
      if (chk_fail) begin
         if (fail_cnt_q == '0)     first_fail_d = IDX_W'(pop_ent.idx);
         if (fail_cnt_q != CNT_MAX) fail_cnt_d  = fail_cnt_q + 1'b1;
      end
      if (state_q == IDLE && start) begin
         fail_cnt_d   = '0;
         first_fail_d = '0;
      end
      if (state_q == DONE) pass_d = (fail_cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_q        <= '0;
         drn_q        <= '0;
         fail_cnt_q   <= '0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
      end else begin
         iss_q        <= iss_d;
         drn_q        <= drn_d;
         fail_cnt_q   <= fail_cnt_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end

   assign fail_cnt   = fail_cnt_q;
   assign first_fail = first_fail_q;
   assign pass       = pass_q;

endmodule

// File: tb/tb_tinker_commit_checker.sv
// Bench for tinker_commit_checker: directed vector table, corner sequences,
// randomized runs against a per-entry window model, and a 1-entry/1-cycle variant.
module tb_tinker_commit_checker;
   import tinker_pkg::*;

   localparam int N  = 16;
   localparam int L  = 4;
   localparam int RL = N + L + 2;   // run offsets 0 (start) .. N+L+1 (done)

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, cfg_we, cfg_chk, start, wb_en;
   logic [3:0]  cfg_idx;
   logic [31:0] cfg_instr, instr;
   logic [4:0]  cfg_exp_reg, wb_reg, fail_cnt;
   logic [63:0] cfg_exp_dat, wb_dat;
   logic        instr_valid, busy, done, pass;
   logic [3:0]  first_fail;

   tinker_commit_checker #(.NUM_ENT(N), .COMMIT_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_instr(cfg_instr), .cfg_chk(cfg_chk), .cfg_exp_reg(cfg_exp_reg),
      .cfg_exp_dat(cfg_exp_dat), .start(start), .instr(instr),
      .instr_valid(instr_valid), .wb_en(wb_en), .wb_reg(wb_reg), .wb_dat(wb_dat),
      .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
      .first_fail(first_fail));

   logic        b_rst_n, b_cfg_we, b_cfg_chk, b_start, b_wb_en;
   logic [0:0]  b_cfg_idx, b_fail_cnt, b_first_fail;
   logic [31:0] b_cfg_instr, b_instr;
   logic [4:0]  b_cfg_exp_reg, b_wb_reg;
   logic [63:0] b_cfg_exp_dat, b_wb_dat;
   logic        b_instr_valid, b_busy, b_done, b_pass;

   tinker_commit_checker #(.NUM_ENT(1), .COMMIT_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(b_rst_n), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx),
      .cfg_instr(b_cfg_instr), .cfg_chk(b_cfg_chk), .cfg_exp_reg(b_cfg_exp_reg),
      .cfg_exp_dat(b_cfg_exp_dat), .start(b_start), .instr(b_instr),
      .instr_valid(b_instr_valid), .wb_en(b_wb_en), .wb_reg(b_wb_reg),
      .wb_dat(b_wb_dat), .busy(b_busy), .done(b_done), .pass(b_pass),
      .fail_cnt(b_fail_cnt), .first_fail(b_first_fail));

   // reference table and per-offset stimulus plan
   bit [31:0] m_instr [N];
   bit        m_chk   [N];
   bit [4:0]  m_reg   [N];
   bit [63:0] m_dat   [N];
   bit        p_en [RL];
   bit [4:0]  p_reg [RL];
   bit [63:0] p_dat [RL];
   bit        p_start [RL];
   bit        p_we [RL];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string nm;
      int    kind1, ent1, kind2, ent2;
      int    x_fail, x_first;
      bit    x_pass;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_ent(input int k, input bit [31:0] ins, input bit c,
                            input bit [4:0] r, input bit [63:0] d);
      cfg_we = 1'b1; cfg_idx = 4'(k); cfg_instr = ins;
      cfg_chk = c; cfg_exp_reg = r; cfg_exp_dat = d;
      tick();
      cfg_we = 1'b0;
      m_instr[k] = ins; m_chk[k] = c; m_reg[k] = r; m_dat[k] = d;
   endtask

   task automatic load_golden();
      for (int k = 0; k < N; k++) write_ent(k, NOP_INSTR, 1'b0, 5'd0, 64'd0);
      write_ent(0, 32'h00a000b7, 1'b1, 5'd5, 64'd10);
      write_ent(1, 32'h003000d7, 1'b1, 5'd6, 64'd3);
      write_ent(2, 32'h00031420, 1'b1, 5'd1, 64'd13);
      write_ent(3, 32'h00031442, 1'b1, 5'd2, 64'd7);
   endtask

   // correct writebacks land exactly L cycles after each entry's issue cycle (offset k+1)
   task automatic golden_plan();
      for (int o = 0; o < RL; o++) begin
         p_en[o] = 1'b0; p_reg[o] = '0; p_dat[o] = '0; p_start[o] = 1'b0; p_we[o] = 1'b0;
      end
      for (int k = 0; k < N; k++)
         if (m_chk[k]) begin
            p_en[k+1+L] = 1'b1; p_reg[k+1+L] = m_reg[k]; p_dat[k+1+L] = m_dat[k];
         end
   endtask

   task automatic corrupt(input int kind, input int ent);
      int o;
      o = ent + 1 + L;
      case (kind)
         1: begin p_en[o] = 1'b1; p_dat[o] = p_dat[o] - 64'd1; end
         2: begin p_en[o] = 1'b1; p_reg[o] = m_reg[ent] + 5'd1; end
         3: p_en[o] = 1'b0;
         4: begin p_en[ent] = 1'b1; p_reg[ent] = 5'd7; p_dat[ent] = 64'd99; end
         5: for (int k = 0; k < N; k++) begin
               p_en[k+1+L] = 1'b1; p_reg[k+1+L] = m_reg[k] + 5'd1;
            end
         default: ;
      endcase
   endtask

   task automatic model(output int f, output int first);
      bit ok;
      int o;
      f = 0; first = 0;
      for (int k = 0; k < N; k++) begin
         o  = k + 1 + L;
         ok = m_chk[k] ? (p_en[o] && p_reg[o] == m_reg[k] && p_dat[o] == m_dat[k])
                       : !p_en[o];
         if (!ok) begin
            if (f == 0) first = k;
            if (f < N) f++;
         end
      end
   endtask

   task automatic do_run(input string nm, input int e_fail, input int e_first, input bit e_pass);
      bit [31:0] e_instr;
      for (int o = 0; o < RL; o++) begin
         start  = (o == 0) || p_start[o];
         wb_en  = p_en[o]; wb_reg = p_reg[o]; wb_dat = p_dat[o];
         cfg_we = p_we[o];
         cfg_idx = 4'd0; cfg_instr = 32'hdead_beef; cfg_chk = 1'b0;
         cfg_exp_reg = 5'd31; cfg_exp_dat = 64'hbad;
         e_instr = (o >= 1 && o <= N && m_chk[o-1]) ? m_instr[o-1] : NOP_INSTR;
         check({nm, "/vld"},   instr_valid, (o >= 1 && o <= N));
         check({nm, "/instr"}, instr, e_instr);
         check({nm, "/busy"},  busy, (o >= 1));
         check({nm, "/done"},  done, (o == RL - 1));
         tick();
      end
      start = 1'b0; wb_en = 1'b0; cfg_we = 1'b0;
      check({nm, "/done_end"}, done, 1'b0);
      check({nm, "/busy_end"}, busy, 1'b0);
      check({nm, "/pass"}, pass, e_pass);
      check({nm, "/fail_cnt"}, fail_cnt, 64'(e_fail));
      check({nm, "/first_fail"}, first_fail, 64'(e_first));
   endtask

   task automatic run1(input string nm, input bit [63:0] d, input bit e_pass, input bit e_fc);
      b_start = 1'b1;
      check({nm, "/busy0"}, b_busy, 1'b0);
      tick();
      b_start = 1'b0;
      check({nm, "/vld"},   b_instr_valid, 1'b1);
      check({nm, "/instr"}, b_instr, 32'h0004a06a);
      check({nm, "/done1"}, b_done, 1'b0);
      tick();
      b_wb_en = 1'b1; b_wb_reg = 5'd3; b_wb_dat = d;
      check({nm, "/vld2"},  b_instr_valid, 1'b0);
      check({nm, "/instr2"}, b_instr, NOP_INSTR);
      check({nm, "/done2"}, b_done, 1'b0);
      tick();
      b_wb_en = 1'b0;
      check({nm, "/done3"}, b_done, 1'b1);
      tick();
      check({nm, "/done4"}, b_done, 1'b0);
      check({nm, "/busy4"}, b_busy, 1'b0);
      check({nm, "/pass"},  b_pass, e_pass);
      check({nm, "/fail_cnt"}, b_fail_cnt, e_fc);
      check({nm, "/first_fail"}, b_first_fail, 1'b0);
   endtask

   initial begin
      int f, first, r;
      bit [4:0] x;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_instr = '0; cfg_chk = 1'b0;
      cfg_exp_reg = '0; cfg_exp_dat = '0; start = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_dat = '0;
      b_rst_n = 1'b0; b_cfg_we = 1'b0; b_cfg_idx = '0; b_cfg_instr = '0; b_cfg_chk = 1'b0;
      b_cfg_exp_reg = '0; b_cfg_exp_dat = '0; b_start = 1'b0; b_wb_en = 1'b0;
      b_wb_reg = '0; b_wb_dat = '0;
      #2;
      check("rst/instr", instr, NOP_INSTR);
      check("rst/vld", instr_valid, 1'b0);
      check("rst/busy", busy, 1'b0);
      check("rst/done", done, 1'b0);
      check("rst/pass", pass, 1'b0);
      check("rst/fail_cnt", fail_cnt, 0);
      check("rst/first_fail", first_fail, 0);
      tick(); tick();
      rst_n = 1'b1; b_rst_n = 1'b1;
      tick();

      vecs[0] = '{"golden",      0, 0,  0, 0,  0,  0, 1'b1};
      vecs[1] = '{"bad2_bad5",   1, 2,  2, 5,  2,  2, 1'b0};
      vecs[2] = '{"chk0_wb",     2, 9,  0, 0,  1,  9, 1'b0};
      vecs[3] = '{"spur_noslot", 4, 0,  4, L,  0,  0, 1'b1};
      vecs[4] = '{"miss3",       3, 3,  0, 0,  1,  3, 1'b0};
      vecs[5] = '{"spur_done",   4, RL-1, 0, 0, 0, 0, 1'b1};
      vecs[6] = '{"all_fail",    5, 0,  0, 0,  N,  0, 1'b0};
      vecs[7] = '{"last_ent",    1, 15, 0, 0,  1, 15, 1'b0};

      load_golden();
      for (int v = 0; v < 8; v++) begin
         golden_plan();
         corrupt(vecs[v].kind1, vecs[v].ent1);
         corrupt(vecs[v].kind2, vecs[v].ent2);
         do_run(vecs[v].nm, vecs[v].x_fail, vecs[v].x_first, vecs[v].x_pass);
      end

      // start during ISSUE/DONE and a table write during DRAIN must be ignored
      golden_plan();
      p_start[3] = 1'b1; p_start[RL-1] = 1'b1; p_we[N+2] = 1'b1;
      do_run("ignore", 0, 0, 1'b1);
      golden_plan();
      do_run("intact", 0, 0, 1'b1);

      // reset in the third ISSUE cycle
      start = 1'b1; tick(); start = 1'b0; tick(); tick();
      rst_n = 1'b0;
      #1;
      check("midrst/busy", busy, 1'b0);
      check("midrst/instr", instr, NOP_INSTR);
      check("midrst/vld", instr_valid, 1'b0);
      check("midrst/done", done, 1'b0);
      check("midrst/pass", pass, 1'b0);
      check("midrst/fail_cnt", fail_cnt, 0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < L + 2; c++) begin
         check("midrst/no_done", done, 1'b0);
         check("midrst/idle", busy, 1'b0);
         tick();
      end
      golden_plan();
      do_run("post_rst", 0, 0, 1'b1);

      for (int n = 0; n < 24; n++) begin
         for (int k = 0; k < N; k++)
            write_ent(k, $urandom, 1'($urandom_range(1, 0)), 5'($urandom),
                      {$urandom, $urandom});
         golden_plan();
         for (int o = 0; o < RL; o++)
            if (o <= L || o == RL - 1) begin
               p_en[o] = ($urandom_range(2, 0) == 0);
               p_reg[o] = 5'($urandom); p_dat[o] = {$urandom, $urandom};
            end
         for (int k = 0; k < N; k++) begin
            r = $urandom_range(7, 0);
            x = 5'($urandom_range(31, 1));
            if (m_chk[k]) begin
               if (r == 4) p_dat[k+1+L] = m_dat[k] ^ (64'd1 << $urandom_range(63, 0));
               if (r == 5) p_reg[k+1+L] = m_reg[k] ^ x;
               if (r == 6) p_en[k+1+L] = 1'b0;
            end else begin
               p_reg[k+1+L] = 5'($urandom); p_dat[k+1+L] = {$urandom, $urandom};
               p_en[k+1+L] = (r >= 5);
            end
         end
         model(f, first);
         do_run("rnd", f, first, f == 0);
      end

      b_cfg_we = 1'b1; b_cfg_idx = 1'b0; b_cfg_instr = 32'h0004a06a;
      b_cfg_chk = 1'b1; b_cfg_exp_reg = 5'd3; b_cfg_exp_dat = 64'h66;
      tick();
      b_cfg_we = 1'b0;
      run1("n1_ok", 64'h66, 1'b1, 1'b0);
      run1("n1_bad", 64'h65, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
